proc_mem_bridge: RTL and testbench

// Parametrised bridge between the processor's command/ready memory port and a valid/ready word bus.

---
 rtl/proc_mem_bridge.sv | 139 +++++++++++++
 tb/tb_proc_mem_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_bridge.sv
// Bridge from the processor command/ready port to a valid/ready word bus,
// with an interrupt request path and a watchdog on hung bus or irq waits.
module proc_mem_bridge #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8,
   localparam int STRB_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic [1:0]        command,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [STRB_W-1:0] cmd_wstrb,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        error,
   output logic              bus_valid,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [STRB_W-1:0] bus_wstrb,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_err,
   output logic              irq_req,
   input  logic              irq_ack
);
   // state | meaning
   // IDLE  | waiting for a command (ignored while the ready pulse is out)
   // BUS   | bus_valid high, waiting for bus_ready or watchdog expiry
   // IRQ   | irq_req high, waiting for irq_ack or watchdog expiry
   // DONE  | result captured; ready pulses on the following cycle
   typedef enum logic [1:0] {IDLE, BUS, IRQ, DONE} state_t;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_IRQ   = 2'b11;
   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_BUS   = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;

   localparam logic [ADDR_W-1:0]    ALIGN_MASK = ~(ADDR_W'(STRB_W - 1));
   localparam logic [TIMEOUT_W-1:0] WD_ONES    = '1;
   // Down-counter: loaded with ones-1 so terminal count lands after 2**TIMEOUT_W-1 waits
   localparam logic [TIMEOUT_W-1:0] WD_LOAD    = WD_ONES - TIMEOUT_W'(1);

   state_t               state, state_nxt;
   logic [TIMEOUT_W-1:0] wdog;
   logic                 take_cmd;
   logic                 wd_term;

   assign inst_addr = pc & ALIGN_MASK;
   assign wd_term   = (wdog == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take_cmd  = 1'b0;
      case (state)
         IDLE: begin
            if (!ready && command != CMD_NONE) begin
               take_cmd  = 1'b1;
               state_nxt = (command == CMD_IRQ) ? IRQ : BUS;
            end
         end
         BUS:     if (bus_ready || wd_term) state_nxt = DONE;
         IRQ:     if (irq_ack || wd_term)   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ready     <= 1'b0;
         rdata     <= '0;
         error     <= ERR_OK;
         bus_valid <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
         irq_req   <= 1'b0;
         wdog      <= '0;
      end else begin
         ready <= (state == DONE);
         case (state)
            IDLE: begin
               if (take_cmd) begin
                  wdog <= WD_LOAD;
                  if (command == CMD_IRQ) begin
                     irq_req <= 1'b1;
                  end else begin
                     bus_valid <= 1'b1;
                     bus_we    <= (command == CMD_WRITE);
                     bus_addr  <= cmd_addr & ALIGN_MASK;
                     bus_wdata <= cmd_wdata;
                     bus_wstrb <= (command == CMD_WRITE) ? cmd_wstrb : '0;
                  end
               end
            end
            BUS: begin
               if (bus_ready) begin
                  bus_valid <= 1'b0;
                  if (!bus_we) rdata <= bus_rdata;
                  error <= bus_err ? ERR_BUS : ERR_OK;
                  wdog  <= '0;
               end else if (wd_term) begin
                  bus_valid <= 1'b0;
                  error     <= ERR_TMO;
               end else begin
                  wdog <= wdog - TIMEOUT_W'(1);
               end
            end
            IRQ: begin
               if (irq_ack) begin
                  irq_req <= 1'b0;
                  error   <= ERR_OK;
                  wdog    <= '0;
               end else if (wd_term) begin
                  irq_req <= 1'b0;
                  error   <= ERR_TMO;
               end else begin
                  wdog <= wdog - TIMEOUT_W'(1);
               end
            end
            default: wdog <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_mem_bridge.sv
// Directed bench for proc_mem_bridge: 32-bit build with a short watchdog,
// plus a 64-bit build to check address alignment at the wider word size.
module tb_proc_mem_bridge;
   logic        clk = 1'b0;
   logic        rstn;

   logic [31:0] pc, inst_addr, cmd_addr, cmd_wdata, rdata, bus_addr, bus_wdata, bus_rdata;
   logic [1:0]  command, error;
   logic [3:0]  cmd_wstrb, bus_wstrb;
   logic        ready, bus_valid, bus_we, bus_ready, bus_err, irq_req, irq_ack;

   logic [31:0] b_pc, b_inst_addr, b_cmd_addr, b_bus_addr;
   logic [63:0] b_cmd_wdata, b_rdata, b_bus_wdata, b_bus_rdata;
   logic [1:0]  b_command, b_error;
   logic [7:0]  b_cmd_wstrb, b_bus_wstrb;
   logic        b_ready, b_bus_valid, b_bus_we, b_bus_ready, b_bus_err, b_irq_req, b_irq_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   proc_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
      .clk(clk), .rstn(rstn), .pc(pc), .inst_addr(inst_addr),
      .command(command), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .ready(ready), .rdata(rdata), .error(error),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
      .irq_req(irq_req), .irq_ack(irq_ack)
   );

   proc_mem_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_W(8)) dut64 (
      .clk(clk), .rstn(rstn), .pc(b_pc), .inst_addr(b_inst_addr),
      .command(b_command), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .cmd_wstrb(b_cmd_wstrb),
      .ready(b_ready), .rdata(b_rdata), .error(b_error),
      .bus_valid(b_bus_valid), .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
      .bus_wstrb(b_bus_wstrb), .bus_ready(b_bus_ready), .bus_rdata(b_bus_rdata), .bus_err(b_bus_err),
      .irq_req(b_irq_req), .irq_ack(b_irq_ack)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Issue one bus command, hold bus_ready low for 'stall' cycles, respond,
   // and return at the negedge where the ready pulse should be visible.
   task automatic xfer(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp_addr, input logic [3:0] exp_ws,
                       input int stall, input logic [31:0] rd, input logic err);
      command = cmd; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
      tick();
      command = 2'b00;
      for (int i = 0; i <= stall; i++) begin
         chk("bus_valid_held", bus_valid, 1'b1);
         chk("bus_addr", bus_addr, exp_addr);
         chk("bus_we", bus_we, cmd[1]);
         chk("bus_wstrb", bus_wstrb, exp_ws);
         if (cmd[1]) chk("bus_wdata", bus_wdata, wd);
         chk("ready_during_bus", ready, 1'b0);
         if (i == stall) begin
            bus_ready = 1'b1; bus_rdata = rd; bus_err = err;
         end
         tick();
      end
      bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      chk("bus_valid_drop", bus_valid, 1'b0);
      chk("ready_early", ready, 1'b0);
      tick();
      chk("ready_pulse", ready, 1'b1);
   endtask

   initial begin
      int n;
      rstn = 1'b0;
      pc = 32'h0; command = 2'b00; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      bus_ready = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0; irq_ack = 1'b0;
      b_pc = 32'h0; b_command = 2'b00; b_cmd_addr = 32'h0; b_cmd_wdata = 64'h0; b_cmd_wstrb = 8'h0;
      b_bus_ready = 1'b1; b_bus_rdata = 64'h0123_4567_89AB_CDEF; b_bus_err = 1'b0; b_irq_ack = 1'b0;
      repeat (2) tick();

      chk("rst_ready", ready, 1'b0);
      chk("rst_bus_valid", bus_valid, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_irq_req", irq_req, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wstrb", bus_wstrb, 4'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_error", error, 2'b00);
      rstn = 1'b1;
      tick();

      pc = 32'h0000_1003;
      b_pc = 32'h0000_1237;
      #1;
      chk("inst_addr32", inst_addr, 32'h0000_1000);
      chk("inst_addr64", b_inst_addr, 32'h0000_1230);

      // 64-bit build: always-ready bus, unaligned address
      b_command = 2'b01; b_cmd_addr = 32'h0000_200F;
      tick();
      b_command = 2'b00;
      chk("b_bus_valid", b_bus_valid, 1'b1);
      chk("b_bus_addr", b_bus_addr, 32'h0000_2008);
      tick();
      chk("b_bus_valid_drop", b_bus_valid, 1'b0);
      tick();
      chk("b_ready", b_ready, 1'b1);
      chk("b_rdata", b_rdata, 64'h0123_4567_89AB_CDEF);
      tick();
      chk("b_ready_once", b_ready, 1'b0);

      // read, unaligned address, response in second bus cycle
      xfer(2'b01, 32'h0000_1003, 32'h0, 4'hF, 32'h0000_1000, 4'h0, 1, 32'hDEAD_BEEF, 1'b0);
      chk("rd_rdata", rdata, 32'hDEAD_BEEF);
      chk("rd_error", error, 2'b00);
      tick();
      chk("rd_ready_once", ready, 1'b0);

      // write, 5 stalled cycles; rdata must be left alone
      xfer(2'b10, 32'h0000_2004, 32'h1122_3344, 4'b0110, 32'h0000_2004, 4'b0110, 5, 32'h5555_5555, 1'b0);
      chk("wr_error", error, 2'b00);
      chk("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
      tick();
      chk("wr_ready_once", ready, 1'b0);

      // bus never answers: 15 cycles of bus_valid, then timeout
      command = 2'b01; cmd_addr = 32'h0000_3000;
      tick();
      command = 2'b00;
      n = 0;
      while (bus_valid && n < 40) begin
         n++;
         tick();
      end
      chk("tmo_valid_cycles", n, 15);
      chk("tmo_ready_early", ready, 1'b0);
      tick();
      chk("tmo_ready", ready, 1'b1);
      chk("tmo_error", error, 2'b10);
      tick();
      chk("tmo_ready_once", ready, 1'b0);

      // bus error, then a clean read clears it
      xfer(2'b01, 32'h0000_0042, 32'h0, 4'h0, 32'h0000_0040, 4'h0, 0, 32'hCAFE_F00D, 1'b1);
      chk("berr_error", error, 2'b01);
      chk("berr_rdata", rdata, 32'hCAFE_F00D);
      tick();
      xfer(2'b01, 32'h0000_0044, 32'h0, 4'h0, 32'h0000_0044, 4'h0, 2, 32'h0BAD_C0DE, 1'b0);
      chk("ok_error", error, 2'b00);
      chk("ok_rdata", rdata, 32'h0BAD_C0DE);
      tick();

      // interrupt: ack after 3 cycles; a read command held throughout must wait for IDLE
      command = 2'b11;
      tick();
      command = 2'b01; cmd_addr = 32'h0000_0808;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         if (irq_req) n++;
         if (i == 2) irq_ack = 1'b1;
         tick();
      end
      irq_ack = 1'b0;
      chk("irq_high_cycles", n, 3);
      chk("irq_dropped", irq_req, 1'b0);
      chk("irq_ready_early", ready, 1'b0);
      chk("irq_no_bus_in_done", bus_valid, 1'b0);
      tick();
      chk("irq_ready", ready, 1'b1);
      chk("irq_error", error, 2'b00);
      chk("irq_no_bus_in_ready", bus_valid, 1'b0);
      tick();
      chk("irq_ready_once", ready, 1'b0);
      chk("held_cmd_waits", bus_valid, 1'b0);
      tick();
      command = 2'b00;
      chk("held_cmd_starts", bus_valid, 1'b1);
      chk("held_cmd_addr", bus_addr, 32'h0000_0808);
      bus_ready = 1'b1; bus_rdata = 32'h7777_0000;
      tick();
      bus_ready = 1'b0;
      tick();
      chk("held_cmd_ready", ready, 1'b1);
      tick();

      // reset in the middle of a transfer
      command = 2'b01; cmd_addr = 32'h0000_5008;
      tick();
      command = 2'b00;
      chk("pre_rst_valid", bus_valid, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("arst_bus_valid", bus_valid, 1'b0);
      chk("arst_bus_addr", bus_addr, 32'h0);
      chk("arst_rdata", rdata, 32'h0);
      chk("arst_error", error, 2'b00);
      chk("arst_ready", ready, 1'b0);
      tick();
      rstn = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ready || bus_valid) n++;
      end
      chk("post_rst_quiet", n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
